// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops one byte at a time from an
// async FIFO and sends it as 8N1 on tx, LSB first.
module fifo_uart_tx #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          rd_q, rd_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tick;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        rd_d    = 1'b0;
        tx_d    = tx_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    rd_d    = 1'b1;
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            // FIFO data is valid one cycle after the pop edge
            S_LOAD: begin
                shreg_d = fifo_dout;
                tx_d    = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    cnt_d   = '0;
                    tx_d    = shreg_q[0];
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            rd_q    <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            rd_q    <= rd_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rd_en = rd_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign byte_done  = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model + scoreboard, UART line decoder
// as monitor, plus a CLK_DIV=2 instance for the short-bit case.
module tb_fifo_uart_tx;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en, tx, busy, byte_done;

    logic       e2 = 1'b1;
    logic [7:0] d2 = 8'h80;
    logic       rd2, tx2, busy2, done2;

    int checks = 0;
    int failures = 0;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int         start_cyc[$];

    int cyc = 0, rd_cnt = 0, frames = 0;
    int tx_low_cnt = 0, last_rd = -100, stray_done = 0;
    bit in_frame = 0;
    int k = 0;
    logic [9:0]     bitv;
    logic [10*D-1:0] tlog;
    bit bd_bad, busy_bad;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLK_DIV(D)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .tx(tx),
        .busy(busy), .byte_done(byte_done)
    );

    fifo_uart_tx #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .fifo_empty(e2), .fifo_dout(d2),
        .fifo_rd_en(rd2), .tx(tx2),
        .busy(busy2), .byte_done(done2)
    );

    // FIFO model: pop on rd_en edge, registered dout
    always @(posedge clk)
        if (fifo_rd_en && fq.size() > 0)
            fifo_dout <= fq.pop_front();

    always @(negedge clk)
        fifo_empty = (fq.size() == 0);

    task automatic chk(input string name,
                       input longint act,
                       input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        #1;
        fq.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0 ||
                busy || in_frame) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_in_budget", n < budget, 1);
        @(negedge clk);
    endtask

    // Monitor: decode the UART line and score each frame
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            in_frame = 0;
            continue;
        end
        if (fifo_rd_en) begin
            rd_cnt++;
            chk("rd_en_gap", (cyc - last_rd) > 1, 1);
            last_rd = cyc;
        end
        if (tx == 1'b0) tx_low_cnt++;
        if (!in_frame) begin
            if (byte_done) stray_done++;
            if (tx == 1'b0) begin
                in_frame = 1;
                k = 0;
                frames++;
                bd_bad = 0;
                busy_bad = 0;
                start_cyc.push_back(cyc);
                chk("rd_to_start_latency", cyc - last_rd, 2);
            end
        end
        if (in_frame) begin
            if (k < 10*D) begin
                tlog[k] = tx;
                if (k % D == D/2) bitv[k/D] = tx;
                if (byte_done) bd_bad = 1;
                if (!busy) busy_bad = 1;
                k++;
            end else begin
                int bad = 0;
                for (int i = 0; i < 10*D; i++)
                    if (tlog[i] !== bitv[i/D]) bad++;
                chk("start_bit", bitv[0], 0);
                chk("stop_bit", bitv[9], 1);
                chk("bit_len_glitches", bad, 0);
                chk("byte_done_pulse", byte_done, 1);
                chk("byte_done_early", bd_bad, 0);
                chk("busy_in_frame", busy_bad, 0);
                chk("busy_after_frame", busy, 0);
                chk("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    chk("byte", bitv[8:1], exp_q.pop_front());
                in_frame = 0;
            end
        end
    end

    initial begin
        int r0, f0, l0, s0, n;
        logic [19:0] tv, ev;
        logic [9:0]  fb;
        logic [7:0]  b;
        bit          dbad;
        int          rdc;

        // 1: reset with FIFO non-empty
        push(8'($urandom));
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_byte_done", byte_done, 0);
        rst_n = 1'b1;
        wait_idle(500);

        // 2: single byte A5
        r0 = rd_cnt;
        f0 = frames;
        push(8'hA5);
        wait_idle(500);
        chk("a5_rd_pulses", rd_cnt - r0, 1);
        chk("a5_frames", frames - f0, 1);
        chk("a5_fifo_empty", fifo_empty, 1);
        chk("a5_busy_low", busy, 0);

        // 3: back-to-back 00,FF,55
        r0 = rd_cnt;
        f0 = frames;
        s0 = start_cyc.size();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        wait_idle(1000);
        chk("b2b_rd_pulses", rd_cnt - r0, 3);
        chk("b2b_frames", frames - f0, 3);
        if (start_cyc.size() >= s0 + 3) begin
            chk("b2b_gap1", start_cyc[s0+1] - start_cyc[s0], 10*D + 3);
            chk("b2b_gap2", start_cyc[s0+2] - start_cyc[s0+1], 10*D + 3);
        end else begin
            chk("b2b_starts", start_cyc.size() - s0, 3);
        end

        // random bytes with random gaps
        r0 = rd_cnt;
        for (int i = 0; i < 20; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_idle(2000);
        chk("rand_rd_pulses", rd_cnt - r0, 20);

        // 4: reset during data bit 3
        push(8'($urandom));
        r0 = rd_cnt;
        n = 0;
        while (rd_cnt == r0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rd_seen", rd_cnt - r0, 1);
        repeat (2 + 4*D + 1) @(negedge clk);
        chk("mid_in_frame", in_frame, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_tx_async", tx, 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        r0 = rd_cnt;
        l0 = tx_low_cnt;
        f0 = frames;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("post_rst_rd_en", rd_cnt - r0, 0);
        chk("post_rst_tx_low", tx_low_cnt - l0, 0);
        chk("post_rst_frames", frames - f0, 0);
        chk("post_rst_busy", busy, 0);

        // 5: empty FIFO for 1000 clocks
        r0 = rd_cnt;
        l0 = tx_low_cnt;
        repeat (1000) @(negedge clk);
        chk("idle_rd_en", rd_cnt - r0, 0);
        chk("idle_tx_low", tx_low_cnt - l0, 0);
        chk("idle_tx", tx, 1);
        chk("stray_byte_done", stray_done, 0);

        // 6: CLK_DIV=2, byte 80
        b = 8'h80;
        d2 = b;
        fb = {1'b1, b, 1'b0};
        for (int j = 0; j < 20; j++) ev[j] = fb[j/2];
        @(negedge clk);
        e2 = 1'b0;
        n = 0;
        while (!rd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("d2_rd_seen", rd2, 1);
        e2 = 1'b1;
        rdc = 0;
        dbad = 0;
        @(negedge clk);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            tv[j] = tx2;
            if (done2) dbad = 1;
            if (rd2) rdc++;
        end
        chk("d2_frame_bits", tv, ev);
        chk("d2_done_early", dbad, 0);
        chk("d2_extra_rd", rdc, 0);
        @(negedge clk);
        chk("d2_byte_done", done2, 1);
        chk("d2_busy_after", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
